// File: rtl/pinv_pkg.sv
// Shared definitions for the pseudoinverse datapath: fixed-point format,
// row-sequencer state encoding and the divider tag record.
package pinv_pkg;

  // Signed fixed point: 1 sign + 16 integer + 15 fraction bits.
  localparam int PINV_NBITS     = 32;
  localparam int PINV_FRAC_BITS = 15;
  localparam int PINV_COL_W     = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // One in-flight division: which column its quotient belongs to.
  typedef struct packed {
    logic                  valid;
    logic [PINV_COL_W-1:0] col;
  } tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// Valid + payload shift register, DEPTH stages, advancing only when en_i is
// high. clr_i synchronously drops every valid bit; payloads are don't-care
// while invalid so they carry no reset. pend_o reports valid entries that
// have not yet reached the output stage.
module tag_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             pend_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Valid bits: cleared by clr_i, shifted one stage per enabled cycle.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
    end else if (en_i) begin
      valid_q[0] <= in_valid_i;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Payloads follow their valid bits down the line.
  always_ff @(posedge clk) begin
    if (en_i) begin
      data_q[0] <= in_data_i;
      for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end
  end

  // Any valid entry upstream of the output stage.
  always_comb begin
    pend_o = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pend_o = pend_o | valid_q[i];
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/div_row_sequencer.sv
// Row-normalisation sequencer: latches a pivot, streams one row from row
// memory into the external divider one element per cycle and writes each
// quotient back to its column. A tag line matched to the divider latency
// tells which column each returning quotient belongs to.
// Optional feature macro: DIVROW_ZERO_CHECK_EN (zero pivot short-circuits
// straight to DONE with err set, touching neither memory nor divider).
//
// Handshake: start is a single-cycle request honoured only in IDLE; done is
// a single-cycle completion pulse; rd_data is valid the cycle after rd_en;
// div_res is the quotient for the operands presented DIV_LATENCY enabled
// cycles earlier; wr_en strobes one write per cycle with no back-pressure.
module div_row_sequencer
  import pinv_pkg::*;
#(
  parameter int NBITS       = PINV_NBITS,
  parameter int NCOLS       = 8,
  parameter int COL_W       = PINV_COL_W,
  parameter int DIV_LATENCY = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] pivot,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [COL_W-1:0] rd_addr,
  input  logic [NBITS-1:0] rd_data,
  output logic             wr_en,
  output logic [COL_W-1:0] wr_addr,
  output logic [NBITS-1:0] wr_data,
  output logic             div_ce,
  output logic [NBITS-1:0] div_a,
  output logic [NBITS-1:0] div_b,
  input  logic [NBITS-1:0] div_res,
  output state_e           dbg_state
);

  state_e           state_q;
  logic [NBITS-1:0] piv_q;
  logic             busy_q;
  logic             done_q;
  logic             rd_en_q;
  logic [COL_W-1:0] rd_addr_q;
  logic             pres_q;      // rd_data this cycle belongs to a row read
  logic [COL_W-1:0] pres_col_q;  // column of that read
  logic             zero_hit;
  logic             tag_valid;
  logic [COL_W-1:0] tag_col;
  logic             tag_pend;

`ifdef DIVROW_ZERO_CHECK_EN
  logic err_q;
  assign zero_hit = (pivot == '0);
  assign err      = err_q;
`else
  assign zero_hit = 1'b0;
  assign err      = 1'b0;
`endif

  // Control FSM: IDLE -> ISSUE (NCOLS reads) -> DRAIN (wait for tags) -> DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      piv_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
`ifdef DIVROW_ZERO_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            piv_q <= pivot;
            if (zero_hit) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
`ifdef DIVROW_ZERO_CHECK_EN
              err_q   <= 1'b1;
`endif
            end else begin
              state_q   <= S_ISSUE;
              busy_q    <= 1'b1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (rd_addr_q == COL_W'(NCOLS - 1)) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + COL_W'(1);
          end
        end
        S_DRAIN: begin
          // Only the output stage (written this cycle) may still be valid.
          if (!tag_pend && !pres_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`ifdef DIVROW_ZERO_CHECK_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Remember which read the memory is answering this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pres_q     <= 1'b0;
      pres_col_q <= '0;
    end else begin
      pres_q     <= rd_en_q;
      pres_col_q <= rd_addr_q;
    end
  end

  assign div_ce = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign div_a  = div_ce ? rd_data : '0;
  assign div_b  = piv_q;

  tag_delay_line #(
    .DEPTH (DIV_LATENCY),
    .WIDTH (COL_W)
  ) u_tags (
    .clk         (clk),
    .clr_i       (rst),
    .en_i        (div_ce),
    .in_valid_i  (pres_q),
    .in_data_i   (pres_col_q),
    .out_valid_o (tag_valid),
    .out_data_o  (tag_col),
    .pend_o      (tag_pend)
  );

  assign wr_en     = tag_valid;
  assign wr_addr   = tag_valid ? tag_col : '0;
  assign wr_data   = tag_valid ? div_res : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_row_sequencer.sv
// Bench for div_row_sequencer with a behavioural row memory and a 4-cycle
// fixed-point divider. Expected quotients come from plain arithmetic on the
// row contents; expected timing comes from the job schedule (element k read
// in cycle k, written in cycle k+1+LAT, done in cycle NC+LAT+1).
module tb_div_row_sequencer;
  import pinv_pkg::*;

  localparam int NB       = 32;
  localparam int NC       = 8;
  localparam int CW       = 3;
  localparam int LAT      = 4;
  localparam int DONE_REL = NC + LAT + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NB-1:0] pivot = '0;
  logic          busy, done, err, rd_en, wr_en, div_ce;
  logic [CW-1:0] rd_addr, wr_addr;
  logic [NB-1:0] rd_data = '0;
  logic [NB-1:0] wr_data, div_a, div_b, div_res;
  state_e        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  div_row_sequencer #(
    .NBITS       (NB),
    .NCOLS       (NC),
    .COL_W       (CW),
    .DIV_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pivot     (pivot),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .div_ce    (div_ce),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_res   (div_res),
    .dbg_state (dbg_state)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [NB-1:0] fx_div(input logic [NB-1:0] a, input logic [NB-1:0] b);
    longint sa, sb;
    if (b == '0) return '1;
    sa = longint'(signed'(a)) <<< 15;
    sb = longint'(signed'(b));
    return NB'(sa / sb);
  endfunction

  // ---------------- environment: row memory and divider ----------------
  logic [NB-1:0] mem      [NC];
  logic [NB-1:0] row_init [NC];
  logic          load_row = 1'b0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (load_row) begin
      for (int i = 0; i < NC; i++) mem[i] <= row_init[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic [NB-1:0] dpipe [LAT];
  always @(posedge clk) begin
    if (div_ce) begin
      dpipe[0] <= fx_div(div_a, div_b);
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign div_res = dpipe[LAT-1];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [CW+NB-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  int   t0 = 32'h3fff_ffff;
  bit   mon_en = 1'b1;
  bit   job_over;
  int   busy_cnt, busy_lo, busy_hi, rd_cnt, rd_bad, wr_cnt, done_cnt, done_rel;
  logic done_err;

  // Monitor: samples on the falling edge, relative to cycle 0 of the job.
  always @(negedge clk) begin
    int rel;
    logic [CW+NB-1:0] w;
    rel = cyc - t0;
    if (mon_en && rel >= 0) begin
      if (busy) begin
        if (busy_cnt == 0) busy_lo = rel;
        busy_hi = rel;
        busy_cnt++;
      end
      if (rd_en) begin
        rd_cnt++;
        if (rel >= NC || int'(rd_addr) != rel) rd_bad++;
      end
      if (wr_en) begin
        wr_cnt++;
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("write_data", 64'({wr_addr, wr_data}), 64'(w));
          check("write_cycle", 64'(rel), 64'(1 + LAT + int'(w[CW+NB-1:NB])));
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        done_err = err;
        job_over = 1'b1;
      end
    end
  end

  function automatic logic outputs_nonzero();
    return busy | done | err | rd_en | wr_en | div_ce | (|rd_addr) | (|wr_addr)
         | (|wr_data) | (|div_a) | (|div_b);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [NB-1:0] piv);
    @(negedge clk); #1;
    t0 = cyc + 1;
    busy_cnt = 0; busy_lo = -1; busy_hi = -1; rd_cnt = 0; rd_bad = 0;
    wr_cnt = 0; done_cnt = 0; done_rel = -1; done_err = 1'b0; job_over = 1'b0;
    load_row = 1'b1;
    start    = 1'b1;
    pivot    = piv;
    @(negedge clk); #1;
    load_row = 1'b0;
    start    = 1'b0;
    pivot    = $urandom;   // later pivot changes must not matter
  endtask

  task automatic run_job(input logic [NB-1:0] piv, input bit inject, input logic [NB-1:0] other);
    bit zero_path;
`ifdef DIVROW_ZERO_CHECK_EN
    zero_path = (piv == '0);
`else
    zero_path = 1'b0;
`endif
    exp_q.delete();
    if (!zero_path)
      for (int k = 0; k < NC; k++) exp_q.push_back({CW'(k), fx_div(row_init[k], piv)});
    start_job(piv);
    for (int i = 0; i < 200 && !job_over; i++) begin
      @(negedge clk); #1;
      if (inject) begin
        if (cyc - t0 == 3) begin start = 1'b1; pivot = other; end
        else start = 1'b0;
      end
    end
    if (inject) begin
      start = 1'b0;
      repeat (NC + LAT + 4) @(negedge clk);
      #1;
    end
    check("job_finished", 64'(job_over), 64'(1));
    check("done_cycle", 64'(done_rel), zero_path ? 64'(0) : 64'(DONE_REL));
    check("done_count", 64'(done_cnt), 64'(1));
    check("err", 64'(done_err), 64'(zero_path));
    check("busy_cycles", 64'(busy_cnt), zero_path ? 64'(0) : 64'(DONE_REL + 1));
    if (!zero_path) check("busy_span", {32'(busy_lo), 32'(busy_hi)}, {32'd0, 32'(DONE_REL)});
    check("reads", {32'(rd_cnt), 32'(rd_bad)}, {zero_path ? 32'd0 : 32'(NC), 32'd0});
    check("write_count", 64'(wr_cnt), zero_path ? 64'(0) : 64'(NC));
  endtask

  task automatic reset_mid_job(input logic [NB-1:0] piv);
    bit clean, untouched;
    clean = 1'b1;
    untouched = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NC; k++) row_init[k] = $urandom;
    start_job(piv);
    while (cyc - t0 < 6) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (outputs_nonzero()) clean = 1'b0;
      @(negedge clk); #1;
    end
    for (int k = 2; k < NC; k++) if (mem[k] !== row_init[k]) untouched = 1'b0;
    check("reset_outputs_quiet", 64'(clean), 64'(1));
    check("reset_no_late_write", 64'(untouched), 64'(1));
    check("reset_early_write", 64'(mem[0]), 64'(fx_div(row_init[0], piv)));
    mon_en = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NB-1:0] piv;
    logic [NB-1:0] a;
    int            col;
    logic [NB-1:0] q;
  } vec_t;
  vec_t tbl[6];

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{32'h0001_0000, 32'h0002_0000, 0, 32'h0001_0000};  //  4.0 /  2.0 =  2.0
    tbl[1] = '{32'h0000_4000, 32'hFFFE_8000, 3, 32'hFFFD_0000};  // -3.0 /  0.5 = -6.0
    tbl[2] = '{32'h0000_8000, 32'h1234_5678, 5, 32'h1234_5678};  //  x   /  1.0 =  x
    tbl[3] = '{32'hFFFF_8000, 32'h0001_8000, 7, 32'hFFFE_8000};  //  3.0 / -1.0 = -3.0
    tbl[4] = '{32'h0001_8000, 32'h0000_8000, 1, 32'h0000_2AAA};  //  1.0 /  3.0, truncated
    tbl[5] = '{32'h0001_0000, 32'hFFFF_8000, 6, 32'hFFFF_C000};  // -1.0 /  2.0 = -0.5

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outputs_nonzero()), 64'(0));
    check("reset_state_idle", 64'(dbg_state == S_IDLE), 64'(1));
    @(negedge clk); #1;
    rst = 1'b0;

    // Basic row: 2.0..16.0 / 2.0
    for (int k = 0; k < NC; k++) row_init[k] = 32'h0001_0000 * (k + 1);
    run_job(32'h0001_0000, 1'b0, '0);
    for (int k = 0; k < NC; k++) check("basic_row", 64'(mem[k]), 64'(32'h0000_8000 * (k + 1)));

    // Table vectors, other columns random
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < NC; k++) row_init[k] = $urandom;
      row_init[tbl[v].col] = tbl[v].a;
      run_job(tbl[v].piv, 1'b0, '0);
      check("table", 64'(mem[tbl[v].col]), 64'(tbl[v].q));
    end

    // Zero pivot
    for (int k = 0; k < NC; k++) row_init[k] = $urandom;
    run_job('0, 1'b0, '0);

    // Start while busy, with a different pivot
    for (int k = 0; k < NC; k++) row_init[k] = $urandom_range(32'h0040_0000, 0);
    run_job(32'h0000_C000, 1'b1, 32'h0003_0000);

    // Reset mid-job, then a fresh job
    reset_mid_job(32'h0001_0000);
    for (int k = 0; k < NC; k++) row_init[k] = $urandom;
    run_job(32'h0002_0000, 1'b0, '0);

    // Back-to-back jobs
    for (int k = 0; k < NC; k++) row_init[k] = $urandom;
    run_job(32'h0000_6000, 1'b0, '0);
    for (int k = 0; k < NC; k++) row_init[k] = $urandom;
    run_job(32'hFFFE_0000, 1'b0, '0);

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      logic [NB-1:0] p;
      p = $urandom;
      if (j % 2 == 0) p = NB'($signed(p) >>> $urandom_range(14, 4));
      if (p == '0) p = 32'h0000_0001;
      for (int k = 0; k < NC; k++) row_init[k] = $urandom;
      run_job(p, (j % 4 == 3), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_row_sequencer.md
# div_row_sequencer

Row-normalisation sequencer for the pseudoinverse datapath. It sits directly upstream of the fixed-point divider stage and also consumes that stage's results. On `start` it latches a pivot, streams the NCOLS elements of one matrix row out of row memory into the divider one per cycle, and writes each quotient back to the same address. It is fully pipelined: one division in flight per cycle, tracked by a tag pipeline matched to the divider latency.

## Interface
- NBITS, 32, operand/result width; signed fixed point, 1 sign + 16 integer + 15 fraction bits.
- NCOLS, 8, elements per row.
- COL_W, 3, column address width; NCOLS ≤ 2^COL_W.
- DIV_LATENCY, 36, cycles from operand presented on `div_a/div_b` to quotient valid on `div_res`; ≥ 1.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- pivot  in  NBITS  divisor, sampled with `start`.
- busy  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- done  out  1  one-cycle pulse, job complete.
- err  out  1  zero pivot detected; valid with `done`.
- rd_en  out  1  row memory read strobe.
- rd_addr  out  COL_W  read column.
- rd_data  in  NBITS  read data, valid 1 cycle after `rd_en`.
- wr_en  out  1  write-back strobe.
- wr_addr  out  COL_W  write column.
- wr_data  out  NBITS  quotient.
- div_ce  out  1  divider clock enable.
- div_a  out  NBITS  dividend.
- div_b  out  NBITS  divisor.
- div_res  in  NBITS  divider quotient, same fixed-point format.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `start` latches `pivot` into `piv_q`.
  - Next state is ISSUE, or DONE if zero-check fires (see Configuration).
- **ISSUE**
  - Lasts exactly NCOLS cycles.
  - Cycle k (k = 0..NCOLS-1): `rd_en`=1, `rd_addr`=k.
  - Then go to DRAIN.
- **Divider feed**
  - `div_a` = `rd_data` combinationally; `div_b` = `piv_q`.
  - `div_ce` = 1 in every state except IDLE and DONE.
- **Tag pipeline**
  - Shift register of {valid, col}, DIV_LATENCY deep, advancing every `div_ce` cycle.
  - Entry for element k enters in ISSUE cycle k+1, when its `rd_data` is presented.
- **Write-back**
  - When the tag output is valid: `wr_en`=1, `wr_addr`=tag col, `wr_data`=`div_res`.
- **DRAIN**
  - Wait until the tag pipeline holds no valid entries and the last write has completed, then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **Boundary rules**
  - `start` outside IDLE is ignored.
  - `pivot` changes after acceptance have no effect.
  - Arithmetic is owned by the divider; `wr_data` is `div_res` bit-exact, with no rounding or saturation here.
  - `rst` at any time: state→IDLE, tag valids cleared, all outputs 0 the following cycle. No write completes after reset, including in-flight quotients.

## Timing
- Reset value of every output is 0.
- Cycle 0 is the first ISSUE cycle (the cycle after `start`).
- Element k: read in cycle k, presented to the divider in cycle k+1, written in cycle k+1+DIV_LATENCY.
- Last write is in cycle NCOLS+DIV_LATENCY. `done` is in cycle NCOLS+DIV_LATENCY+1.
- Throughput: one element per cycle.
- Next `start` is accepted the cycle after `done`.

## Configuration
- `DIVROW_ZERO_CHECK_EN` defined:
  - `pivot`==0 at `start` goes IDLE→DONE directly.
  - `done`=1 and `err`=1 in cycle 0.
  - No reads, no divider activity, row memory untouched.
- `DIVROW_ZERO_CHECK_EN` undefined:
  - `err` is tied 0.
  - A zero pivot runs a normal job; results are whatever the divider returns.

## Structure
- Shared package `pinv_pkg` holds:
  - the fixed-point constants (NBITS, fraction-bit count 15);
  - the state enum typedef;
  - the tag struct {valid, col}.
- One sub-module: `tag_delay_line`, a parameterised depth/width valid+payload shift register with enable and synchronous clear.
- The divider itself is not instantiated here; it connects externally via the `div_*` ports.

## Test plan
Benches use DIV_LATENCY=4, NCOLS=8, and a behavioural divider model with 4-cycle latency.
1. **Basic row:** row = 2.0,4.0,…,16.0 (0x00010000·k), pivot 2.0 (0x00010000).
   - Writes of 1.0..8.0 at cols 0..7 in cycles 5..12.
   - `done` in cycle 13; `busy` high cycles 0..13.
2. **Negative/fractional:** row[3] = −3.0 (0xFFFE8000), pivot 0.5 (0x00004000).
   - `wr_data` at col 3 = −6.0 (0xFFFD0000).
3. **Zero pivot, macro defined:** pivot 0.
   - `done`=`err`=1 in cycle 0.
   - No `rd_en`, no `wr_en`, `busy` stays 0.
4. **Start while busy:** second `start` in cycle 3 with a different pivot.
   - Ignored; all 8 results use the first pivot; exactly one `done`.
5. **Reset mid-job:** `rst` in cycle 6.
   - No `wr_en` from cycle 7 on; outputs 0.
   - A fresh `start` after reset completes normally.
6. **Back-to-back jobs:** `start` in the cycle after `done`.
   - Second job's reads begin the next cycle; both rows written correctly.
